fft_out_reorder: RTL and testbench

Downstream stage of the constant multiplier in the 8-point FFT pipeline. Takes the (total_bits+1)-bit rotated complex samples, narrows them back to total_bits with rounding, and reorders each frame from bit-reversed to natural order. A two-bank ping-pong buffer lets one frame be written while the previous one is read out.

---
 rtl/fft_out_pkg.sv | 50 +++++
 rtl/fft_pingpong_ram.sv | 34 +++
 rtl/fft_out_reorder.sv | 135 +++++++++++++
 tb/tb_fft_out_reorder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_pkg.sv
// fft_out_pkg: shared helpers for the FFT output reorder stage.
//   - bitrev(): bit-reverses the low nbits of an index (nbits up to 6).
//   - narrow_val()/narrow_sat(): narrow a (total_bits+1)-bit sample to
//     total_bits, carried in 65/64-bit containers so one function serves
//     any width up to 64.
//   - localparams with the default geometry and output limits.
// Build option: define ROUND_SAT_EN for round-half-up with saturation;
// otherwise narrowing is a plain arithmetic shift (truncation).
package fft_out_pkg;

    localparam int     TOTAL_BITS = 32;
    localparam int     NPOINTS    = 8;
    localparam int     ADDR_W     = $clog2(NPOINTS);
    localparam longint OUT_MAX    = (64'sd1 <<< (TOTAL_BITS - 1)) - 64'sd1;
    localparam longint OUT_MIN    = -(64'sd1 <<< (TOTAL_BITS - 1));

    function automatic logic [5:0] bitrev(input logic [5:0] a, input int nbits);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < nbits) r[i] = a[nbits - 1 - i];
        end
        return r;
    endfunction

    // x is sign-extended to 65 bits; tb is the output width.
    function automatic logic signed [63:0] narrow_val(input logic signed [64:0] x,
                                                      input int tb);
        logic signed [64:0] s;
`ifdef ROUND_SAT_EN
        logic signed [64:0] mx;
        s  = (x + 65'sd1) >>> 1;
        mx = (65'sd1 <<< (tb - 1)) - 65'sd1;
        // Only the largest positive input can round past the output range.
        if (s > mx) s = mx;
`else
        s = x >>> 1;
`endif
        return s[63:0];
    endfunction

`ifdef ROUND_SAT_EN
    function automatic logic narrow_sat(input logic signed [64:0] x, input int tb);
        logic signed [64:0] s;
        s = (x + 65'sd1) >>> 1;
        return (s > ((65'sd1 <<< (tb - 1)) - 65'sd1));
    endfunction
`endif

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of npoints words, one write port and one
// read port, bank chosen by a single bit on each port.
//   CLK            clock (write is synchronous)
//   i_we           write enable
//   i_wbank/i_waddr/i_wdata  write bank, address, data
//   i_rbank/i_raddr          read bank, address
//   o_rdata        combinational read data
// Contents are never reset.
module fft_pingpong_ram
    import fft_out_pkg::*;
#(
    parameter int DW      = 2 * (TOTAL_BITS + 1),
    parameter int npoints = NPOINTS
) (
    input  logic                       CLK,
    input  logic                       i_we,
    input  logic                       i_wbank,
    input  logic [$clog2(npoints)-1:0] i_waddr,
    input  logic [DW-1:0]              i_wdata,
    input  logic                       i_rbank,
    input  logic [$clog2(npoints)-1:0] i_raddr,
    output logic [DW-1:0]              o_rdata
);
    localparam int AW = $clog2(npoints);

    logic [DW-1:0] r_mem [0:2*npoints-1];

    always_ff @(posedge CLK) begin
        if (i_we) r_mem[{i_wbank, i_waddr}] <= i_wdata;
    end

    assign o_rdata = r_mem[{i_rbank, i_raddr}];

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: narrows (total_bits+1)-bit complex samples to total_bits
// and reorders each frame from bit-reversed to natural order through a
// ping-pong buffer, so one frame is written while the previous one is read.
//   CLK, RST     clock, synchronous active-high reset
//   ED           clock enable; all state holds while low
//   START        marks input sample 0 of a frame
//   DIR/DII      input real/imag, signed, total_bits+1 wide
//   DOR/DOI      registered output real/imag, signed, total_bits wide
//   RDY          high with output sample 0 of a frame
//   OVF          sticky saturation flag (only with ROUND_SAT_EN)
// Build option: ROUND_SAT_EN selects rounding with saturation.
module fft_out_reorder
    import fft_out_pkg::*;
#(
    parameter int total_bits = TOTAL_BITS,
    parameter int npoints    = NPOINTS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ED,
    input  logic                  START,
    input  logic [total_bits:0]   DIR,
    input  logic [total_bits:0]   DII,
    output logic [total_bits-1:0] DOR,
    output logic [total_bits-1:0] DOI,
    output logic                  RDY,
    output logic                  OVF
);
    localparam int            AW   = $clog2(npoints);
    localparam int            DW   = 2 * (total_bits + 1);
    localparam logic [AW-1:0] LAST = AW'(npoints - 1);

    logic [AW-1:0]         r_wc;
    logic [AW-1:0]         r_rc;
    logic                  r_wsel;
    logic                  r_wact;
    logic                  r_ract;
    logic [total_bits-1:0] r_dor;
    logic [total_bits-1:0] r_doi;
    logic                  r_rdy;

    logic                  w_we;
    logic [AW-1:0]         w_waddr;
    logic [AW-1:0]         w_raddr;
    logic [DW-1:0]         w_rdata;
    logic signed [64:0]    w_xre;
    logic signed [64:0]    w_xim;
    logic [total_bits-1:0] w_yre;
    logic [total_bits-1:0] w_yim;

    // START always lands at address 0, restarting any partial frame.
    assign w_we    = ED && (START || r_wact);
    assign w_waddr = START ? '0 : r_wc;
    assign w_raddr = AW'(bitrev(6'(r_rc), AW));

    fft_pingpong_ram #(
        .DW      (DW),
        .npoints (npoints)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_wbank (r_wsel),
        .i_waddr (w_waddr),
        .i_wdata ({DIR, DII}),
        .i_rbank (~r_wsel),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign w_xre = {{(64-total_bits){w_rdata[DW-1]}}, w_rdata[DW-1:total_bits+1]};
    assign w_xim = {{(64-total_bits){w_rdata[total_bits]}}, w_rdata[total_bits:0]};
    assign w_yre = total_bits'(narrow_val(w_xre, total_bits));
    assign w_yim = total_bits'(narrow_val(w_xim, total_bits));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wc   <= '0;
            r_rc   <= '0;
            r_wsel <= 1'b0;
            r_wact <= 1'b0;
            r_ract <= 1'b0;
            r_dor  <= '0;
            r_doi  <= '0;
            r_rdy  <= 1'b0;
        end else if (ED) begin
            if (r_ract) begin
                r_dor <= w_yre;
                r_doi <= w_yim;
                r_rdy <= (r_rc == '0);
                r_rc  <= r_rc + 1'b1;
                if (r_rc == LAST) r_ract <= 1'b0;
            end else begin
                r_rdy <= 1'b0;
            end

            // Placed after the read side: on back-to-back frames the final
            // read and the next frame completion share an edge, and the new
            // read must win.
            if (START) begin
                r_wc   <= AW'(1);
                r_wact <= 1'b1;
            end else if (r_wact) begin
                if (r_wc == LAST) begin
                    r_wc   <= '0;
                    r_wact <= 1'b0;
                    r_wsel <= ~r_wsel;
                    r_rc   <= '0;
                    r_ract <= 1'b1;
                end else begin
                    r_wc <= r_wc + 1'b1;
                end
            end
        end
    end

`ifdef ROUND_SAT_EN
    logic r_ovf;
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (ED && r_ract &&
                     (narrow_sat(w_xre, total_bits) || narrow_sat(w_xim, total_bits))) begin
            r_ovf <= 1'b1;
        end
    end
    assign OVF = r_ovf;
`else
    assign OVF = 1'b0;
`endif

    assign DOR = r_dor;
    assign DOI = r_doi;
    assign RDY = r_rdy;

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed bench for fft_out_reorder (32-bit, 8-point).
// Write address a holds the sample of natural index bitrev(a), so a value
// written as 2*bitrev(a) reappears at natural output index bitrev(a).
module tb_fft_out_reorder;

    logic        CLK;
    logic        RST;
    logic        ED;
    logic        START;
    logic [32:0] DIR;
    logic [32:0] DII;
    logic [31:0] DOR;
    logic [31:0] DOI;
    logic        RDY;
    logic        OVF;

    int total;
    int bad;
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_out_reorder #(
        .total_bits (32),
        .npoints    (8)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .ED    (ED),
        .START (START),
        .DIR   (DIR),
        .DII   (DII),
        .DOR   (DOR),
        .DOI   (DOI),
        .RDY   (RDY),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic [32:0] re, input logic [32:0] im,
                        input logic ed, input logic rst);
        START = st;
        DIR   = re;
        DII   = im;
        ED    = ed;
        RST   = rst;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        longint dor_exp [4];
        longint ovf_exp;
        longint exp_dor;
        longint exp_rdy;
        int     n_ed;
        int     iter;
        logic   ed;

        total = 0;
        bad   = 0;
        START = 1'b0;
        DIR   = '0;
        DII   = '0;
        ED    = 1'b1;
        RST   = 1'b1;

        // Reset state
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b1);
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b1);
        check("rst_dor", longint'($signed(DOR)), 0);
        check("rst_doi", longint'($signed(DOI)), 0);
        check("rst_rdy", longint'(RDY), 0);
        check("rst_ovf", longint'(OVF), 0);

        // Frame 1: natural output k from input 2k
        for (int i = 0; i < 8; i++) begin
            step(i == 0, 33'(2 * br[i]), 33'(2 * br[i]), 1'b1, 1'b0);
            check("f1_wr_rdy", longint'(RDY), 0);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
            check("f1_dor", longint'($signed(DOR)), longint'(k));
            check("f1_doi", longint'($signed(DOI)), longint'(k));
            check("f1_rdy", longint'(RDY), longint'(k == 0));
        end
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
        check("f1_hold_dor", longint'($signed(DOR)), 7);
        check("f1_hold_rdy", longint'(RDY), 0);

        // Bit-reverse: write a holds 16*a, output k = 8*bitrev(k)
        for (int i = 0; i < 8; i++)
            step(i == 0, 33'(16 * i), 33'(16 * i), 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
            check("br_dor", longint'($signed(DOR)), longint'(8 * br[k]));
        end

        // Back-to-back frames: A then B starting right after A completes
        for (int i = 0; i < 8; i++)
            step(i == 0, 33'(2 * br[i]), 33'(-2 * br[i]), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(i == 0, 33'(2 * (br[i] + 20)), 33'(-2 * (br[i] + 20)), 1'b1, 1'b0);
            check("b2b_a_dor", longint'($signed(DOR)), longint'(i));
            check("b2b_a_doi", longint'($signed(DOI)), longint'(-i));
            check("b2b_a_rdy", longint'(RDY), longint'(i == 0));
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
            check("b2b_b_dor", longint'($signed(DOR)), longint'(k + 20));
            check("b2b_b_doi", longint'($signed(DOI)), longint'(-(k + 20)));
            check("b2b_b_rdy", longint'(RDY), longint'(k == 0));
        end
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
        check("b2b_end_rdy", longint'(RDY), 0);
        check("b2b_end_dor", longint'($signed(DOR)), 27);

        // Narrowing corners: out k=0..3 come from write addresses 0,4,2,6
`ifdef ROUND_SAT_EN
        dor_exp = '{2, -1, 64'sd2147483647, -64'sd2147483648};
`else
        dor_exp = '{1, -2, 64'sd2147483647, -64'sd2147483648};
`endif
        for (int i = 0; i < 8; i++) begin
            logic [32:0] v;
            case (i)
                0:       v = 33'd3;
                4:       v = 33'h1_FFFF_FFFD;
                2:       v = 33'h0_FFFF_FFFF;
                6:       v = 33'h1_0000_0000;
                default: v = 33'd0;
            endcase
            step(i == 0, v, v, 1'b1, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
`ifdef ROUND_SAT_EN
            ovf_exp = (k >= 2) ? 1 : 0;
`else
            ovf_exp = 0;
`endif
            check("nar_ovf", longint'(OVF), ovf_exp);
            if (k < 4) begin
                check("nar_dor", longint'($signed(DOR)), dor_exp[k]);
                check("nar_doi", longint'($signed(DOI)), dor_exp[k]);
            end
        end
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
`ifdef ROUND_SAT_EN
        check("ovf_sticky", longint'(OVF), 1);
`else
        check("ovf_tied", longint'(OVF), 0);
`endif
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b1);
        check("ovf_rst", longint'(OVF), 0);
        check("nar_rst_dor", longint'($signed(DOR)), 0);

        // Random ED during a frame: same sequence, holds while ED=0
        n_ed    = 0;
        iter    = 0;
        exp_dor = 0;
        exp_rdy = 0;
        while (n_ed < 16 && iter < 400) begin
            ed = ($urandom_range(0, 1) == 1);
            if (n_ed < 8)
                step(n_ed == 0, 33'(2 * br[n_ed]), 33'(2 * br[n_ed]), ed, 1'b0);
            else
                step(1'b0, 33'd0, 33'd0, ed, 1'b0);
            if (ed) begin
                n_ed++;
                if (n_ed >= 9) begin
                    exp_dor = longint'(n_ed - 9);
                    exp_rdy = longint'(n_ed == 9);
                end
            end
            check("ed_dor", longint'($signed(DOR)), exp_dor);
            check("ed_rdy", longint'(RDY), exp_rdy);
            iter++;
        end
        check("ed_done", longint'(n_ed), 16);
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
        check("ed_tail_rdy", longint'(RDY), 0);

        // START again at write index 5, then reset mid-read
        for (int i = 0; i < 5; i++)
            step(i == 0, 33'(2 * (br[i] + 50)), 33'(2 * (br[i] + 50)), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            step(i == 0, 33'(2 * (br[i] + 30)), 33'(2 * (br[i] + 30)), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 33'd0, 33'd0, 1'b1, 1'b0);
            check("rs_dor", longint'($signed(DOR)), longint'(k + 30));
            check("rs_rdy", longint'(RDY), longint'(k == 0));
        end
        step(1'b0, 33'd0, 33'd0, 1'b1, 1'b1);
        check("mid_rst_dor", longint'($signed(DOR)), 0);
        check("mid_rst_doi", longint'($signed(DOI)), 0);
        check("mid_rst_rdy", longint'(RDY), 0);
        check("mid_rst_ovf", longint'(OVF), 0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 33'd6, 33'd6, 1'b1, 1'b0);
            check("post_rst_dor", longint'($signed(DOR)), 0);
            check("post_rst_rdy", longint'(RDY), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
